// File: rtl/el2_div_noc_pkg.sv
// el2_div_noc_pkg: shared types and constants for the EXU <-> NoC divider client.
// Latency: n/a (declarations only).
// Backpressure: n/a. Holds flit layout, FSM states, packet sizes, default node addresses.
package el2_div_noc_pkg;

  localparam int DEF_FLIT_DATA_BITS = 16;
  localparam int DEF_ADDR_BITS      = 4;
  localparam int DEF_DIV_PKT_BITS   = 3;

  localparam int REQ_FLITS        = 5;
  localparam int RSP_FLITS        = 2;
  localparam int REQ_PAYLOAD_BITS = REQ_FLITS * DEF_FLIT_DATA_BITS;  // 80

  localparam logic [DEF_ADDR_BITS-1:0] DEF_SRC_ADDR = 4'd1;  // this client
  localparam logic [DEF_ADDR_BITS-1:0] DEF_DST_ADDR = 4'd2;  // divider node

  // On-wire flit: {last, dst, data}, MSB first.
  typedef struct packed {
    logic                          last;
    logic [DEF_ADDR_BITS-1:0]      dst;
    logic [DEF_FLIT_DATA_BITS-1:0] data;
  } div_noc_flit_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    WAIT   = 3'd2,
    CANCEL = 3'd3,
    DRAIN  = 3'd4
  } state_t;

endpackage

// File: rtl/el2_div_noc_flit_tx.sv
// el2_div_noc_flit_tx: shifts a REQ_FLITS-flit payload out MS chunk first; last flag on final flit.
// Latency: first flit valid the cycle after load; one flit per cycle with tx_ready held high.
// Backpressure: flit held stable while tx_ready is low; done pulses when the last flit is accepted.
// Ports: load/payload start a packet (load wins over an in-flight packet), tx_valid/tx_ready/tx_flit
//        toward the NoC, done is a combinational pulse on the accepting cycle of the final flit.
module el2_div_noc_flit_tx
  import el2_div_noc_pkg::*;
#(
  parameter int                    FLIT_DATA_BITS = DEF_FLIT_DATA_BITS,
  parameter int                    ADDR_BITS      = DEF_ADDR_BITS,
  parameter logic [ADDR_BITS-1:0]  DST_ADDR       = DEF_DST_ADDR
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load,
  input  logic [REQ_FLITS*FLIT_DATA_BITS-1:0] payload,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic [ADDR_BITS+FLIT_DATA_BITS:0]   tx_flit,
  output logic                                done
);

  localparam int PW = REQ_FLITS * FLIT_DATA_BITS;
  localparam int CW = $clog2(REQ_FLITS);
  localparam logic [CW-1:0] LAST_IDX = CW'(REQ_FLITS - 1);

  logic [PW-1:0] shift_q;
  logic [CW-1:0] idx_q;
  logic          active_q;
  logic          is_last;

  assign is_last  = (idx_q == LAST_IDX);
  assign tx_valid = active_q;
  assign done     = active_q & tx_ready & is_last;
  // Zero the bus when idle so nothing downstream sees a stale header.
  assign tx_flit  = active_q ? {is_last, DST_ADDR, shift_q[PW-1 -: FLIT_DATA_BITS]} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      shift_q  <= payload;
      idx_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q && tx_ready) begin
      if (is_last) begin
        active_q <= 1'b0;
      end else begin
        idx_q   <= idx_q + 1'b1;
        shift_q <= shift_q << FLIT_DATA_BITS;
      end
    end
  end

endmodule

// File: rtl/el2_exu_div_noc_client.sv
// el2_exu_div_noc_client: EXU-side divider client; 5-flit request out, 2-flit result in, cancel+drain on flush.
// Latency: 5 send cycles (no stalls) + NoC/divider round trip + 1 to result_valid.
// Backpressure: tx stalls hold the flit; rx never stalls (rx_ready=1), bad flits are dropped with rx_err.
// Ports: req_* handshake from EXU, flush kills the op, result_valid/result_data back to EXU,
//        tx_* / rx_* flit channels toward the NoC, busy = operation in flight.
// Build option: define EL2_DIV_NOC_ZERO_BYPASS_EN to answer divide-by-zero locally without NoC traffic.
module el2_exu_div_noc_client
  import el2_div_noc_pkg::*;
#(
  parameter int                   FLIT_DATA_BITS = DEF_FLIT_DATA_BITS,
  parameter int                   ADDR_BITS      = DEF_ADDR_BITS,
  parameter logic [ADDR_BITS-1:0] SRC_ADDR       = DEF_SRC_ADDR,
  parameter logic [ADDR_BITS-1:0] DST_ADDR       = DEF_DST_ADDR,
  parameter int                   DIV_PKT_BITS   = DEF_DIV_PKT_BITS,
  parameter int                   DRAIN_TIMEOUT  = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [31:0]                       req_dividend,
  input  logic [31:0]                       req_divisor,
  input  logic [DIV_PKT_BITS-1:0]           req_dp,
  input  logic                              flush,
  output logic                              result_valid,
  output logic [31:0]                       result_data,
  output logic                              busy,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic [ADDR_BITS+FLIT_DATA_BITS:0] tx_flit,
  input  logic                              rx_valid,
  output logic                              rx_ready,
  input  logic [ADDR_BITS+FLIT_DATA_BITS:0] rx_flit,
  output logic                              rx_err
);

  localparam int PW       = REQ_FLITS * FLIT_DATA_BITS;
  localparam int PAD_BITS = PW - DIV_PKT_BITS - 1 - 64;
  localparam int DCW      = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [PW-1:0] CANCEL_PAYLOAD = {{PAD_BITS{1'b0}}, {DIV_PKT_BITS{1'b0}}, 1'b1, 64'b0};

  state_t state_q, state_d;

  logic          accept, zero_div, byp_q;
  logic          req_load, cancel_load, tx_done;
  logic [PW-1:0] tx_payload;
  logic          flush_seen_q;
  logic          rx_cnt_q;
  logic [FLIT_DATA_BITS-1:0] rx_hi_q;
  logic [DCW-1:0] drain_cnt_q;
  logic          drain_expired;
  logic          rx_listen, rx_addr_ok, rx_seq_ok, rx_complete, rx_bad;
  div_noc_flit_t rx_f;

  assign rx_ready = 1'b1;
  assign accept   = req_valid & req_ready;

`ifdef EL2_DIV_NOC_ZERO_BYPASS_EN
  assign zero_div = (req_divisor == 32'd0);
`else
  assign zero_div = 1'b0;
`endif

  // ---------------- rx decode ----------------
  assign rx_f        = rx_flit;
  assign rx_listen   = (state_q == WAIT) || (state_q == DRAIN);
  assign rx_addr_ok  = (rx_f.dst == SRC_ADDR);
  // Flit 0 of the result must have last=0, flit 1 last=1, so last must equal the assembly index.
  assign rx_seq_ok   = (rx_f.last == rx_cnt_q);
  assign rx_complete = rx_valid & rx_listen & rx_addr_ok & rx_cnt_q & rx_f.last;
  assign rx_bad      = rx_valid & (~rx_listen | ~rx_addr_ok | ~rx_seq_ok);

  assign drain_expired = (drain_cnt_q == DCW'(DRAIN_TIMEOUT - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept && !zero_div) state_d = SEND;
      // The request packet always completes; a flush during it turns into a cancel afterwards.
      SEND:   if (tx_done) state_d = (flush_seen_q || flush) ? CANCEL : WAIT;
      WAIT:   if (flush) state_d = CANCEL;
              else if (rx_complete) state_d = IDLE;
      CANCEL: if (tx_done) state_d = DRAIN;
      DRAIN:  if (rx_complete || drain_expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready   = (state_q == IDLE) && !byp_q && !flush && !rst;
    busy        = (state_q != IDLE) || byp_q;
    req_load    = (state_q == IDLE) && (state_d == SEND);
    cancel_load = (state_q != CANCEL) && (state_d == CANCEL);
  end

  assign tx_payload = cancel_load ? CANCEL_PAYLOAD
                                  : {{PAD_BITS{1'b0}}, req_dp, 1'b0, req_dividend, req_divisor};

  el2_div_noc_flit_tx #(
    .FLIT_DATA_BITS (FLIT_DATA_BITS),
    .ADDR_BITS      (ADDR_BITS),
    .DST_ADDR       (DST_ADDR)
  ) u_flit_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (req_load | cancel_load),
    .payload  (tx_payload),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_flit  (tx_flit),
    .done     (tx_done)
  );

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_seen_q <= 1'b0;
      rx_cnt_q     <= 1'b0;
      rx_hi_q      <= '0;
      drain_cnt_q  <= '0;
      rx_err       <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      byp_q        <= 1'b0;
    end else begin
      flush_seen_q <= (state_q == SEND) && (flush_seen_q || flush);
      drain_cnt_q  <= (state_q == DRAIN) ? drain_cnt_q + 1'b1 : '0;
      rx_err       <= rx_bad;
      byp_q        <= accept & zero_div;
      result_valid <= 1'b0;

      // Partial results never survive leaving WAIT/DRAIN or a flush in WAIT.
      if (!rx_listen || (state_q == WAIT && flush)) begin
        rx_cnt_q <= 1'b0;
      end else if (rx_valid && rx_addr_ok) begin
        if (!rx_seq_ok) begin
          rx_cnt_q <= 1'b0;
        end else if (!rx_cnt_q) begin
          rx_hi_q  <= rx_f.data;
          rx_cnt_q <= 1'b1;
        end else begin
          rx_cnt_q <= 1'b0;
        end
      end

      if (state_q == WAIT && !flush && rx_complete) begin
        result_valid <= 1'b1;
        result_data  <= {rx_hi_q, rx_f.data};
      end else if (accept && zero_div) begin
        // RISC-V divide-by-zero: quotient all ones, remainder = dividend.
        result_valid <= 1'b1;
        result_data  <= req_dp[0] ? req_dividend : 32'hFFFF_FFFF;
      end
    end
  end

endmodule
